// File: rtl/chan_demux_pkg.sv
// Package: chan_demux_pkg
// Shared sizing helpers and types for the channel demux buffer.
//   ch_w(n)      : tag width for n channels
//   lvl_w(d)     : width of an occupancy counter that can hold 0..d
//   DROP_CNT_W   : width of each per-channel drop counter
//   demux_word_t : {tag, payload} input word for the default configuration
package chan_demux_pkg;

   localparam int DROP_CNT_W    = 8;
   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_PAYLOAD_W = 2;

   function automatic int ch_w(input int num_ch);
      return $clog2(num_ch);
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int DEF_CH_W = ch_w(DEF_NUM_CH);

   typedef struct packed {
      logic [DEF_CH_W-1:0]      tag;
      logic [DEF_PAYLOAD_W-1:0] payload;
   } demux_word_t;

endpackage

// File: rtl/chan_demux_buffer_fifo.sv
// Module: chan_fifo
// Single-channel circular FIFO with registered level/full/empty flags.
// The read port is combinational from the current read pointer; the
// parent registers the selected channel's word.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en_i       write request (already decoded for this channel)
//   wr_data_i     payload to store
//   rd_en_i       read request (already decoded for this channel)
//   rd_data_o     word at the read pointer
//   rd_ok_o       read request accepted this cycle
//   wr_drop_o     write request rejected this cycle (FIFO full, no read)
//   full_o        level == DEPTH
//   empty_o       level == 0
//   level_o       occupancy 0..DEPTH
module chan_fifo
   import chan_demux_pkg::*;
#(
   parameter int  DEPTH = 6,
   parameter int  WIDTH = 2,
   localparam int LVL_W = lvl_w(DEPTH),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_ok_o,
   output logic             wr_drop_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             wr_do, rd_do;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      rd_do    = rd_en_i && !empty_q;
      // A simultaneous read frees a slot, so a full FIFO still takes the write.
      wr_do    = wr_en_i && (!full_q || rd_do);
      wr_ptr_d = wr_do ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd_do ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      level_d  = level_q + LVL_W'(wr_do) - LVL_W'(rd_do);
      full_d   = (level_d == LVL_W'(DEPTH));
      empty_d  = (level_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is not reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (wr_do) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign rd_ok_o   = rd_do;
   assign wr_drop_o = wr_en_i && !wr_do;
   assign full_o    = full_q;
   assign empty_o   = empty_q;
   assign level_o   = level_q;

endmodule

// File: rtl/chan_demux_buffer.sv
// Module: chan_demux_buffer
// Steers tagged input words into per-channel FIFOs and provides a
// registered, channel-selected read port.
// Optional feature: define DEMUX_DROP_CNT_EN to add per-channel saturating
// drop counters on output drop_cnt.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   in_data valid this cycle
//   in_data    {tag, payload}
//   in_drop    pulse: previous cycle's write was discarded
//   rd_en      read request for channel rd_ch
//   rd_valid   pulse: rd_data carries the word of an accepted read
//   rd_data    last read payload (held between reads)
//   rd_err     pulse: previous read hit an empty or illegal channel
//   full       per-channel full flags
//   empty      per-channel empty flags
//   level      per-channel occupancy, ch0 in the LSBs
//   drop_cnt   (DEMUX_DROP_CNT_EN only) per-channel 8-bit drop counters
module chan_demux_buffer
   import chan_demux_pkg::*;
#(
   parameter int  NUM_CH    = 4,
   parameter int  PAYLOAD_W = 2,
   parameter int  DEPTH     = 6,
   localparam int CH_W      = ch_w(NUM_CH),
   localparam int LVL_W     = lvl_w(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [CH_W+PAYLOAD_W-1:0] in_data,
   output logic                      in_drop,
   input  logic                      rd_en,
   input  logic [CH_W-1:0]           rd_ch,
   output logic                      rd_valid,
   output logic [PAYLOAD_W-1:0]      rd_data,
   output logic                      rd_err,
   output logic [NUM_CH-1:0]         full,
   output logic [NUM_CH-1:0]         empty,
   output logic [NUM_CH*LVL_W-1:0]   level
`ifdef DEMUX_DROP_CNT_EN
  ,output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt
`endif
);

   logic [CH_W-1:0]      in_tag;
   logic [PAYLOAD_W-1:0] in_payload;
   logic                 tag_legal;
   logic [NUM_CH-1:0]    fifo_rd_ok;
   logic [NUM_CH-1:0]    fifo_wr_drop;
   logic [PAYLOAD_W-1:0] fifo_rd_data [NUM_CH];

   logic                 rd_valid_q, rd_valid_d;
   logic [PAYLOAD_W-1:0] rd_data_q, rd_data_d;
   logic                 rd_err_q, rd_err_d;
   logic                 in_drop_q, in_drop_d;

   assign in_tag     = in_data[CH_W+PAYLOAD_W-1 -: CH_W];
   assign in_payload = in_data[PAYLOAD_W-1:0];

   // Only a non-power-of-2 channel count leaves unused tag codes.
   if (NUM_CH == (1 << CH_W)) begin : g_tag_all_legal
      assign tag_legal = 1'b1;
   end else begin : g_tag_range
      assign tag_legal = (int'(in_tag) < NUM_CH);
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      chan_fifo #(
         .DEPTH (DEPTH),
         .WIDTH (PAYLOAD_W)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .wr_en_i   (in_valid && tag_legal && (in_tag == CH_W'(gi))),
         .wr_data_i (in_payload),
         .rd_en_i   (rd_en && (rd_ch == CH_W'(gi))),
         .rd_data_o (fifo_rd_data[gi]),
         .rd_ok_o   (fifo_rd_ok[gi]),
         .wr_drop_o (fifo_wr_drop[gi]),
         .full_o    (full[gi]),
         .empty_o   (empty[gi]),
         .level_o   (level[gi*LVL_W +: LVL_W])
      );
   end

   // Illegal read channels request no FIFO, so they surface as rd_err
   // through the same path as an empty channel.
   always_comb begin
      rd_valid_d = |fifo_rd_ok;
      rd_err_d   = rd_en && !(|fifo_rd_ok);
      rd_data_d  = rd_data_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (fifo_rd_ok[i]) rd_data_d = fifo_rd_data[i];
      end
      in_drop_d  = in_valid && (!tag_legal || (|fifo_wr_drop));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
         in_drop_q  <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
         in_drop_q  <= in_drop_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;
   assign in_drop  = in_drop_q;

`ifdef DEMUX_DROP_CNT_EN
   // Counts only full-FIFO drops; illegal tags never reach a FIFO.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_drop_cnt
      logic [DROP_CNT_W-1:0] cnt_q;
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
         end else if (fifo_wr_drop[gi] && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
      assign drop_cnt[gi*DROP_CNT_W +: DROP_CNT_W] = cnt_q;
   end
`endif

endmodule
